lc3_alu_seq: RTL and testbench
==============================

// Module: lc3_alu_seq
// PURPOSE
//  Parametrised, handshaked successor of the LC-3 datapath ALU. Accepts one
//  operation per transaction on a valid/ready input port and returns a
//  registered result plus NZP condition codes on a valid/ready output port.
//  Extends the op set with SUB, shifts and an iterative multi-cycle MUL.
//  Sits between the register file read ports and the writeback/CC logic.
// PARAMETERS
//  WIDTH      16  datapath width in bits; legal range 4..64.
//  IMM_WIDTH   5  immediate field width; sign-extended to WIDTH; must be < WIDTH.
// PORTS
//  clk        in   1          single clock, rising edge
//  reset      in   1          asynchronous, active-high
//  in_valid   in   1          operation offered
//  in_ready   out  1          block can accept; high only in IDLE
//  op         in   3          000 PASSA, 001 ADD, 010 AND, 011 NOT A,
//                             100 SUB (A-B), 101 SLL, 110 SRA, 111 MUL
//  imm_sel    in   1          1: B = sext(imm); 0: B = rb
//  imm        in   IMM_WIDTH  immediate operand
//  ra         in   WIDTH      operand A
//  rb         in   WIDTH      register operand B
//  out_valid  out  1          result available
//  out_ready  in   1          consumer takes result
//  out_data   out  WIDTH      result
//  out_cc     out  3          {N,Z,P} of out_data
// BEHAVIOUR
//  - Reset (any time, including mid-MUL): state=IDLE, out_valid=0, out_data=0,
//    out_cc=3'b010, and any in-flight op is discarded.
//  - States: IDLE -> (accept, op!=MUL) DONE; IDLE -> (accept, op==MUL) MUL;
//    MUL -> DONE after WIDTH iterations; DONE -> IDLE when out_ready.
//  - Accept means in_valid && in_ready on a rising edge. Operands and op are
//    captured then. B = imm_sel ? sign-extended imm : rb.
//  - Single-cycle ops: out_valid is asserted on the cycle after accept.
//  - MUL: one shift-add step per cycle, WIDTH steps. out_valid is asserted
//    WIDTH+1 cycles after accept. The result is the low WIDTH bits of A*B,
//    which is identical for signed and unsigned operands.
//  - ADD/SUB are modulo 2^WIDTH; no carry or overflow output.
//  - SLL/SRA shift amount = B[$clog2(WIDTH)-1:0]. SRA replicates A[WIDTH-1].
//    Shift by 0 returns A.
//  - out_cc is computed from the registered result. Exactly one bit is set:
//    N if MSB=1, Z if all zero, P otherwise.
//  - out_valid, out_data and out_cc hold stable in DONE until out_ready.
//    in_ready=0 throughout MUL and DONE, so no overlap and no bypass.
//  - in_valid asserted outside IDLE is ignored; it is not queued.
//  - An op change while in_valid && !in_ready has no effect.
// STRUCTURE
//  - Shared package/include alu_pkg: op codes (OP_PASSA..OP_MUL), state
//    encodings (S_IDLE, S_MUL, S_DONE), and a cc_of(result) function.
//  - One sub-module, alu_mult_iter (WIDTH param): start, A, B -> busy, done,
//    product. It owns the iteration counter of $clog2(WIDTH)+1 bits and the
//    accumulator. Top level holds the FSM, the B mux, the single-cycle ops
//    and the output registers.
// TESTING
//  1. Reset: WIDTH=16, assert reset mid-MUL (cycle 5) -> next edge shows
//     out_valid=0, out_data=0, out_cc=010, in_ready=1.
//  2. ADD imm: ra=16'h0005, imm_sel=1, imm=5'b11101 (-3) -> out_data=16'h0002,
//     out_cc=001, out_valid exactly 1 cycle after accept.
//  3. SUB to zero / negative: ra=7, rb=7 -> 0000, cc=010; ra=0, rb=1 -> FFFF,
//     cc=100.
//  4. Shifts: ra=16'h8001, SRA by 4 -> F800; SLL by 15 -> 8000; shift by 0 -> 8001.
//  5. MUL: ra=16'h00FF, rb=16'h0101 -> out_data=16'hFFFF, cc=100; out_valid at
//     accept+17 cycles, in_ready=0 throughout.
//  6. Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 -> out_data
//     and out_cc stable, no second accept; release -> IDLE, next op accepted.

Source files
------------

// File: rtl/lc3_alu_seq_pkg.sv
// Shared definitions for the handshaked LC-3 ALU: op codes, FSM states and
// the condition-code helper.
package lc3_alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_PASSA = 3'b000,
    OP_ADD   = 3'b001,
    OP_AND   = 3'b010,
    OP_NOT   = 3'b011,
    OP_SUB   = 3'b100,
    OP_SLL   = 3'b101,
    OP_SRA   = 3'b110,
    OP_MUL   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [2:0] CC_N = 3'b100;
  localparam logic [2:0] CC_Z = 3'b010;
  localparam logic [2:0] CC_P = 3'b001;

  // {N,Z,P}: exactly one bit set; zero takes priority over sign.
  function automatic logic [2:0] cc_of(input logic msb, input logic is_zero);
    if (is_zero) return CC_Z;
    if (msb) return CC_N;
    return CC_P;
  endfunction

endpackage

// File: rtl/lc3_alu_seq_if.sv
// Operation request / result handshake bundle between the register-file
// read side (master) and the ALU (slave).
interface lc3_alu_seq_if
  import lc3_alu_seq_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int IMM_WIDTH = 5
);

  logic                 in_valid;
  logic                 in_ready;
  op_e                  op;
  logic                 imm_sel;
  logic [IMM_WIDTH-1:0] imm;
  logic [WIDTH-1:0]     ra;
  logic [WIDTH-1:0]     rb;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [2:0]           out_cc;

  modport master (
    output in_valid, op, imm_sel, imm, ra, rb, out_ready,
    input  in_ready, out_valid, out_data, out_cc
  );

  modport slave (
    input  in_valid, op, imm_sel, imm, ra, rb, out_ready,
    output in_ready, out_valid, out_data, out_cc
  );

endinterface

// File: rtl/lc3_alu_seq_mult_iter.sv
// Iterative shift-add multiplier returning the low WIDTH bits of a*b.
// The first partial product is folded into the start cycle, so WIDTH steps end WIDTH-1 cycles later.
module lc3_alu_seq_mult_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = CW'(WIDTH - 1);
      acc_d    = b[0] ? a : '0;
      mcand_d  = a << 1;
      mplier_d = b >> 1;
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        cnt_d    = cnt_q - CW'(1);
        acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Datapath needs no reset: it is only observed while busy_q qualifies it.
  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
  end

  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == '0);
  assign product = acc_q;

endmodule

// File: rtl/lc3_alu_seq.sv
// Handshaked LC-3 ALU: single-cycle ops resolve at accept, MUL runs through
// the iterative multiplier; result and NZP are held until the consumer takes them.
module lc3_alu_seq
  import lc3_alu_seq_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int IMM_WIDTH = 5
) (
  input logic clk,
  input logic reset,
  lc3_alu_seq_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  state_e                   state_q, state_d;
  logic [WIDTH-1:0]         out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [WIDTH-1:0]  a, b, imm_ext, alu_res;
  logic [SHW-1:0]           shamt;
  logic                     in_ready_w, accept, mul_start;
  logic                     mul_busy, mul_done;
  logic [WIDTH-1:0]         mul_prod;

  assign imm_ext = {{(WIDTH - IMM_WIDTH){bus.imm[IMM_WIDTH-1]}}, bus.imm};
  assign a       = bus.ra;
  assign b       = bus.imm_sel ? imm_ext : bus.rb;
  assign shamt   = b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (bus.op)
      OP_PASSA: alu_res = a;
      OP_ADD:   alu_res = a + b;
      OP_AND:   alu_res = a & b;
      OP_NOT:   alu_res = ~a;
      OP_SUB:   alu_res = a - b;
      OP_SLL:   alu_res = a << shamt;
      OP_SRA:   alu_res = a >>> shamt;
      default:  alu_res = '0;
    endcase
  end

  // The busy term keeps a late multiplier from ever overlapping a new accept.
  assign in_ready_w = (state_q == S_IDLE) && !mul_busy;
  assign accept     = bus.in_valid && in_ready_w;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    mul_start   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.op == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = S_MUL;
          end else begin
            out_data_d  = alu_res;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end
      end
      S_MUL: begin
        if (mul_done) begin
          out_data_d  = mul_prod;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  lc3_alu_seq_mult_iter #(.WIDTH(WIDTH)) u_mult (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_cc    = cc_of(out_data_q[WIDTH-1], out_data_q == '0);

endmodule

// File: tb/tb_lc3_alu_seq.sv
// Directed bench for lc3_alu_seq with a transaction-level reference model
// compared against the DUT on every falling edge.
module tb_lc3_alu_seq;
  import lc3_alu_seq_pkg::*;

  localparam int W  = 16;
  localparam int IW = 5;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  lc3_alu_seq_if #(.WIDTH(W), .IMM_WIDTH(IW)) bus ();

  lc3_alu_seq #(.WIDTH(W), .IMM_WIDTH(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: result from plain arithmetic, timing from latency counts.
  function automatic logic [W-1:0] model_res(input op_e op, input logic [W-1:0] a,
                                             input logic [W-1:0] rbv, input logic isel,
                                             input logic [IW-1:0] imm);
    logic [W-1:0] b;
    int sh;
    b  = isel ? W'(int'($signed(imm))) : rbv;
    sh = int'(b % W);
    case (op)
      OP_PASSA: return a;
      OP_ADD:   return a + b;
      OP_AND:   return a & b;
      OP_NOT:   return ~a;
      OP_SUB:   return a - b;
      OP_SLL:   return a << sh;
      OP_SRA:   return W'($signed(a) >>> sh);
      default:  return W'(longint'(a) * longint'(b));
    endcase
  endfunction

  function automatic logic [2:0] model_cc(input logic [W-1:0] d);
    if (d == '0) return 3'b010;
    if ($signed(d) < 0) return 3'b100;
    return 3'b001;
  endfunction

  logic         m_hold, m_busy;
  int           m_remain;
  logic [W-1:0] m_data;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hold   <= 1'b0;
      m_busy   <= 1'b0;
      m_remain <= 0;
      m_data   <= '0;
    end else if (m_hold) begin
      if (bus.out_ready) m_hold <= 1'b0;
    end else if (m_busy) begin
      if (m_remain == 1) begin
        m_busy <= 1'b0;
        m_hold <= 1'b1;
      end
      m_remain <= m_remain - 1;
    end else if (bus.in_valid) begin
      m_data <= model_res(bus.op, bus.ra, bus.rb, bus.imm_sel, bus.imm);
      if (bus.op == OP_MUL) begin
        m_busy   <= 1'b1;
        m_remain <= W;
      end else begin
        m_hold <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("cmp in_ready", 64'(bus.in_ready), 64'(!(m_hold || m_busy)));
      check("cmp out_valid", 64'(bus.out_valid), 64'(m_hold));
      if (m_hold) begin
        check("cmp out_data", 64'(bus.out_data), 64'(m_data));
        check("cmp out_cc", 64'(bus.out_cc), 64'(model_cc(m_data)));
      end
    end
  end

  typedef struct {
    op_e          op;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         isel;
    logic [IW-1:0] imm;
    logic [W-1:0] exp_data;
    logic [2:0]   exp_cc;
    int           exp_lat;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic issue(input op_e op, input logic [W-1:0] ra, input logic [W-1:0] rb,
                       input logic isel, input logic [IW-1:0] imm);
    check("issue in_ready", 64'(bus.in_ready), 64'd1);
    bus.op       = op;
    bus.ra       = ra;
    bus.rb       = rb;
    bus.imm_sel  = isel;
    bus.imm      = imm;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Latency in cycles counted from the accept cycle (1 = valid right after accept edge).
  task automatic wait_valid(output int lat);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    vecs[0]  = '{OP_ADD,   16'h0005, 16'h0000, 1'b1, 5'b11101, 16'h0002, 3'b001, 1};
    vecs[1]  = '{OP_SUB,   16'h0007, 16'h0007, 1'b0, 5'b00000, 16'h0000, 3'b010, 1};
    vecs[2]  = '{OP_SUB,   16'h0000, 16'h0001, 1'b0, 5'b00000, 16'hFFFF, 3'b100, 1};
    vecs[3]  = '{OP_SRA,   16'h8001, 16'h0004, 1'b0, 5'b00000, 16'hF800, 3'b100, 1};
    vecs[4]  = '{OP_SLL,   16'h8001, 16'h000F, 1'b0, 5'b00000, 16'h8000, 3'b100, 1};
    vecs[5]  = '{OP_SLL,   16'h8001, 16'h0000, 1'b0, 5'b00000, 16'h8001, 3'b100, 1};
    vecs[6]  = '{OP_SRA,   16'h8001, 16'h0010, 1'b0, 5'b00000, 16'h8001, 3'b100, 1};
    vecs[7]  = '{OP_PASSA, 16'h7FFF, 16'h1234, 1'b0, 5'b00000, 16'h7FFF, 3'b001, 1};
    vecs[8]  = '{OP_AND,   16'hF0F0, 16'h3C3C, 1'b0, 5'b00000, 16'h3030, 3'b001, 1};
    vecs[9]  = '{OP_NOT,   16'h00FF, 16'h0000, 1'b0, 5'b00000, 16'hFF00, 3'b100, 1};
    vecs[10] = '{OP_SRA,   16'h8000, 16'h0000, 1'b1, 5'b00011, 16'hF000, 3'b100, 1};
    vecs[11] = '{OP_MUL,   16'h00FF, 16'h0101, 1'b0, 5'b00000, 16'hFFFF, 3'b100, 17};
    vecs[12] = '{OP_MUL,   16'hFFFD, 16'h0005, 1'b0, 5'b00000, 16'hFFF1, 3'b100, 17};
    vecs[13] = '{OP_MUL,   16'h0000, 16'h1234, 1'b0, 5'b00000, 16'h0000, 3'b010, 17};
    vecs[14] = '{OP_ADD,   16'h7FFF, 16'h0001, 1'b0, 5'b00000, 16'h8000, 3'b100, 1};
    vecs[15] = '{OP_ADD,   16'hFFFF, 16'h0001, 1'b0, 5'b00000, 16'h0000, 3'b010, 1};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = OP_PASSA;
    bus.imm_sel   = 1'b0;
    bus.imm       = '0;
    bus.ra        = '0;
    bus.rb        = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset out_data", 64'(bus.out_data), 64'h0);
    check("reset out_cc", 64'(bus.out_cc), 64'b010);
    check("reset in_ready", 64'(bus.in_ready), 64'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a multiply
    issue(OP_MUL, 16'h0003, 16'h0004, 1'b0, '0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("midmul in_ready", 64'(bus.in_ready), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midmul rst out_valid", 64'(bus.out_valid), 64'd0);
    check("midmul rst out_data", 64'(bus.out_data), 64'h0);
    check("midmul rst out_cc", 64'(bus.out_cc), 64'b010);
    check("midmul rst in_ready", 64'(bus.in_ready), 64'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("after rst out_valid", 64'(bus.out_valid), 64'd0);

    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].isel, vecs[i].imm);
      wait_valid(lat);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      check($sformatf("vec%0d data", i), 64'(bus.out_data), 64'(vecs[i].exp_data));
      check($sformatf("vec%0d cc", i), 64'(bus.out_cc), 64'(vecs[i].exp_cc));
      check($sformatf("vec%0d in_ready busy", i), 64'(bus.in_ready), 64'd0);
      take();
      check($sformatf("vec%0d released", i), 64'(bus.out_valid), 64'd0);
    end

    // Backpressure with a competing request held on the input
    issue(OP_MUL, 16'h00FF, 16'h0101, 1'b0, '0);
    wait_valid(lat);
    check("bp mul latency", 64'(lat), 64'd17);
    bus.op       = OP_ADD;
    bus.ra       = 16'h1234;
    bus.rb       = 16'h0001;
    bus.imm_sel  = 1'b0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) bus.op = OP_SUB;
      if (k == 6) bus.op = OP_ADD;
      @(posedge clk); #1;
      check("bp hold data", 64'(bus.out_data), 64'hFFFF);
      check("bp hold cc", 64'(bus.out_cc), 64'b100);
      check("bp hold valid", 64'(bus.out_valid), 64'd1);
      check("bp hold in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp release valid", 64'(bus.out_valid), 64'd0);
    check("bp release in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp next valid", 64'(bus.out_valid), 64'd1);
    check("bp next data", 64'(bus.out_data), 64'h1235);
    check("bp next cc", 64'(bus.out_cc), 64'b001);
    take();

    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
